// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_RESET_DEF = 32'hbfc00000;
  localparam logic [31:0] INST_NOP     = 32'h0;

endpackage

// File: rtl/if_fetch_hold_buf.sv
// One-entry {pc,inst} skid buffer that parks a response while the IF/ID register is stalled.
module if_fetch_hold_buf
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_load,
  input  logic              i_drain,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [31:0]       i_inst,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_pc,
  output logic [31:0]       o_inst
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_inst;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= INST_NOP;
    end else if (i_clear || i_drain) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs a single-outstanding instruction bus
// and feeds the IF/ID register, dropping responses made stale by a redirect.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(PC_RESET_DEF)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [31:0]       inst_rdata,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_inst
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_discard;
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_pc;
  logic [31:0]       r_out_inst;

  logic              w_accept;
  logic              w_resp;
  logic              w_keep;
  logic              w_slot_free;
  logic              w_deliver;
  logic              w_park;
  logic              w_drain;
  logic              w_hold_valid;
  logic [ADDR_W-1:0] w_hold_pc;
  logic [31:0]       w_hold_inst;

  assign w_accept    = (r_state == REQ) && inst_addr_ok;
  assign w_resp      = (r_state == WAIT) && inst_data_ok;
  // A response is only worth keeping if no redirect has killed it, earlier or right now.
  assign w_keep      = w_resp && !r_discard && !redirect_i;
  assign w_slot_free = !r_out_valid || !stall_i;
  assign w_deliver   = w_keep && w_slot_free;
  assign w_park      = w_keep && !w_slot_free;
  assign w_drain     = (r_state == HOLD) && !stall_i && !redirect_i;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    w_state_next = REQ;
      REQ:     if (inst_addr_ok) w_state_next = WAIT;
      WAIT:    if (inst_data_ok) w_state_next = w_park ? HOLD : REQ;
      HOLD:    if (redirect_i || !stall_i) w_state_next = REQ;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_pc      <= PC_RESET;
      r_req_pc  <= '0;
      r_discard <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) r_req_pc <= r_pc;
      if (redirect_i) begin
        r_pc      <= redirect_pc;
        // Whatever is in flight after this edge belongs to the old path.
        r_discard <= w_accept || ((r_state == WAIT) && !inst_data_ok);
      end else begin
        if (w_accept) r_pc <= r_pc + ADDR_W'(4);
        if (w_resp) r_discard <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_inst  <= INST_NOP;
    end else if (redirect_i) begin
      r_out_valid <= 1'b0;
    end else if (w_deliver) begin
      r_out_valid <= 1'b1;
      r_out_pc    <= r_req_pc;
      r_out_inst  <= inst_rdata;
    end else if (w_drain) begin
      r_out_valid <= 1'b1;
      r_out_pc    <= w_hold_pc;
      r_out_inst  <= w_hold_inst;
    end else if (!stall_i) begin
      r_out_valid <= 1'b0;
    end
  end

  if_fetch_hold_buf #(
    .ADDR_W (ADDR_W)
  ) u_hold_buf (
    .clk     (clk),
    .resetn  (resetn),
    .i_load  (w_park),
    .i_drain (w_drain),
    .i_clear (redirect_i),
    .i_pc    (r_req_pc),
    .i_inst  (inst_rdata),
    .o_valid (w_hold_valid),
    .o_pc    (w_hold_pc),
    .o_inst  (w_hold_inst)
  );

  assign inst_req  = (r_state == REQ);
  assign inst_addr = r_pc;
  assign out_valid = r_out_valid;
  assign out_pc    = r_out_pc;
  assign out_inst  = r_out_inst;

  // Only meaningful in HOLD; the FSM state already encodes it.
  logic w_unused;
  assign w_unused = w_hold_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench: a bus slave model plus a transaction-level fetch/delivery scoreboard.
module tb_if_fetch_unit;

  localparam logic [31:0] BOOT = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .ADDR_W   (32),
    .PC_RESET (BOOT)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc  (redirect_pc),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .out_valid    (out_valid),
    .out_pc       (out_pc),
    .out_inst     (out_inst)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h13579bdf;
  endfunction

  // Reference model: next fetch pc, the in-flight request, and every instruction owed downstream.
  logic [31:0] m_pc;
  bit          m_inflight;
  bit          m_stale;
  logic [31:0] m_req_pc;
  logic [31:0] m_q[$];
  int          delivered = 0;
  bit          wrap_seen = 1'b0;

  bit          s_busy;
  int          s_cnt;
  logic [31:0] s_addr;

  int  p_stall, p_redir, p_aok, max_dly;
  bit  force_redir = 1'b0;
  logic [31:0] force_pc;

  bit          have_pre;
  bit          pre_stall, pre_redir, pre_ov;
  logic [31:0] pre_pc, pre_inst;

  task automatic model_reset();
    m_pc       = BOOT;
    m_inflight = 1'b0;
    m_stale    = 1'b0;
    m_q.delete();
    s_busy     = 1'b0;
    s_cnt      = 0;
    have_pre   = 1'b0;
  endtask

  task automatic drive_idle();
    stall_i      = 1'b0;
    redirect_i   = 1'b0;
    redirect_pc  = '0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
  endtask

  task automatic cycle();
    logic [31:0] exp_pc;
    @(negedge clk);
    if (have_pre) begin
      if (pre_redir) begin
        check_val("flush_valid", 32'(out_valid), 32'd0);
      end else if (pre_stall && pre_ov) begin
        check_val("stall_valid", 32'(out_valid), 32'd1);
        check_val("stall_pc", out_pc, pre_pc);
        check_val("stall_inst", out_inst, pre_inst);
      end
    end
    stall_i = ($urandom_range(99) < p_stall);
    if (force_redir) begin
      redirect_i  = 1'b1;
      redirect_pc = force_pc;
      force_redir = 1'b0;
    end else begin
      redirect_i = ($urandom_range(99) < p_redir);
      case ($urandom_range(2))
        0:       redirect_pc = 32'h80000180;
        1:       redirect_pc = 32'hfffffff8;
        default: redirect_pc = $urandom & 32'hfffffffc;
      endcase
    end
    inst_addr_ok = inst_req && ($urandom_range(99) < p_aok);
    inst_data_ok = 1'b0;
    inst_rdata   = $urandom;
    if (s_busy) begin
      if (s_cnt == 0) begin
        inst_data_ok = 1'b1;
        inst_rdata   = mem_word(s_addr);
      end else begin
        s_cnt--;
      end
    end

    if (inst_req) begin
      check_val("req_addr", inst_addr, m_pc);
      check_val("one_outstanding", 32'(m_inflight), 32'd0);
    end
    if (!redirect_i && out_valid && !stall_i) begin
      if (m_q.size() == 0) begin
        check_val("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        exp_pc = m_q.pop_front();
        check_val("out_pc", out_pc, exp_pc);
        check_val("out_inst", out_inst, mem_word(exp_pc));
        delivered++;
      end
    end
    if (inst_data_ok) begin
      s_busy = 1'b0;
      if (!redirect_i && !m_stale) m_q.push_back(m_req_pc);
      m_inflight = 1'b0;
    end
    if (redirect_i) begin
      m_q.delete();
      m_stale = 1'b1;
    end
    if (inst_addr_ok) begin
      s_busy     = 1'b1;
      s_cnt      = $urandom_range(max_dly);
      s_addr     = inst_addr;
      m_inflight = 1'b1;
      m_stale    = redirect_i;
      m_req_pc   = m_pc;
      if (m_pc == 32'hfffffffc && !redirect_i) wrap_seen = 1'b1;
      m_pc       = m_pc + 32'd4;
    end
    if (redirect_i) m_pc = redirect_pc;

    pre_stall = stall_i;
    pre_redir = redirect_i;
    pre_ov    = out_valid;
    pre_pc    = out_pc;
    pre_inst  = out_inst;
    have_pre  = 1'b1;
  endtask

  task automatic run(input int n, input int st, input int rd, input int aok, input int dly);
    p_stall = st;
    p_redir = rd;
    p_aok   = aok;
    max_dly = dly;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int d0;
    resetn = 1'b0;
    drive_idle();
    model_reset();
    #1;
    check_val("rst_req", 32'(inst_req), 32'd0);
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_pc", out_pc, 32'd0);
    check_val("rst_out_inst", out_inst, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Zero-wait slave: a delivery every second cycle.
    d0 = delivered;
    run(21, 0, 0, 100, 0);
    check_val("zero_wait_rate", 32'(delivered - d0 >= 8), 32'd1);

    force_redir = 1'b1;
    force_pc    = 32'h80000180;
    run(3000, 30, 5, 60, 3);

    force_redir = 1'b1;
    force_pc    = 32'hfffffff8;
    run(12, 0, 0, 100, 0);
    check_val("wrap_seen", 32'(wrap_seen), 32'd1);

    // Reset mid-transaction, then refetch from the boot vector.
    p_stall = 0; p_redir = 0; p_aok = 100; max_dly = 3;
    for (int i = 0; i < 20 && !s_busy; i++) cycle();
    check_val("reached_wait", 32'(s_busy), 32'd1);
    @(negedge clk);
    resetn = 1'b0;
    drive_idle();
    #1;
    check_val("midrst_req", 32'(inst_req), 32'd0);
    check_val("midrst_valid", 32'(out_valid), 32'd0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    run(1000, 20, 3, 70, 2);

    check_val("deliveries", 32'(delivered > 300), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
